// File: rtl/byte_counter.sv
// Per-frame header byte counter: counts accepted beat bytes from frame start,
// flags header completion and records where the header ends in the crossing beat.
module byte_counter #(
    parameter  int DATA_WIDTH     = 64,
    parameter  int HEADER_BYTES   = 18,
    localparam int BYTES_PER_BEAT = DATA_WIDTH / 8,
    localparam int CNT_W          = $clog2(HEADER_BYTES + BYTES_PER_BEAT) + 1,
    localparam int OFF_W          = $clog2(BYTES_PER_BEAT) + 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_beat_accept,
    input  logic             i_frame_start,
    output logic             o_header_done,
    output logic             o_header_done_pulse,
    output logic [CNT_W-1:0] o_byte_count,
    output logic [OFF_W-1:0] o_header_end_offset
);

    localparam logic [CNT_W-1:0] HB_C  = CNT_W'(HEADER_BYTES);
    localparam logic [CNT_W-1:0] BPB_C = CNT_W'(BYTES_PER_BEAT);

    logic [CNT_W-1:0] r_count;
    logic             r_pulse;
    logic [OFF_W-1:0] r_offset;

    logic             w_below;
    logic [CNT_W-1:0] w_next_count;

    // r_count < HEADER_BYTES whenever we add, so the sum stays below HB+BPB.
    assign w_below      = (r_count < HB_C);
    assign w_next_count = r_count + BPB_C;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count  <= '0;
            r_pulse  <= 1'b0;
            r_offset <= '0;
        end else if (i_frame_start) begin
            r_count <= i_beat_accept ? BPB_C : '0;
            if (i_beat_accept && (BPB_C >= HB_C)) begin
                r_offset <= OFF_W'(HB_C);
                r_pulse  <= 1'b1;
            end else begin
                r_offset <= '0;
                r_pulse  <= 1'b0;
            end
        end else if (i_beat_accept && w_below) begin
            r_count <= w_next_count;
            if (w_next_count >= HB_C) begin
                r_offset <= OFF_W'(HB_C - r_count);
                r_pulse  <= 1'b1;
            end else begin
                r_pulse  <= 1'b0;
            end
        end else begin
            r_pulse <= 1'b0;
        end
    end

    assign o_header_done       = ~w_below;
    assign o_header_done_pulse = r_pulse;
    assign o_byte_count        = r_count;
    assign o_header_end_offset = r_offset;

endmodule

// File: tb/tb_byte_counter.sv
// Directed bench for byte_counter: default config via a vector table, plus
// hand sequences for the 8-bit and 256-bit data width corners.
module tb_byte_counter;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic beat_accept = 1'b0;
    logic frame_start = 1'b0;

    always #5 clk = ~clk;

    logic       d64_done, d64_pulse;
    logic [5:0] d64_cnt;
    logic [3:0] d64_off;
    logic       d8_done, d8_pulse;
    logic [5:0] d8_cnt;
    logic [0:0] d8_off;
    logic       d256_done, d256_pulse;
    logic [6:0] d256_cnt;
    logic [5:0] d256_off;

    byte_counter u_d64 (
        .i_clk(clk), .i_rst(rst), .i_beat_accept(beat_accept), .i_frame_start(frame_start),
        .o_header_done(d64_done), .o_header_done_pulse(d64_pulse),
        .o_byte_count(d64_cnt), .o_header_end_offset(d64_off)
    );

    byte_counter #(.DATA_WIDTH(8), .HEADER_BYTES(18)) u_d8 (
        .i_clk(clk), .i_rst(rst), .i_beat_accept(beat_accept), .i_frame_start(frame_start),
        .o_header_done(d8_done), .o_header_done_pulse(d8_pulse),
        .o_byte_count(d8_cnt), .o_header_end_offset(d8_off)
    );

    byte_counter #(.DATA_WIDTH(256), .HEADER_BYTES(18)) u_d256 (
        .i_clk(clk), .i_rst(rst), .i_beat_accept(beat_accept), .i_frame_start(frame_start),
        .o_header_done(d256_done), .o_header_done_pulse(d256_pulse),
        .o_byte_count(d256_cnt), .o_header_end_offset(d256_off)
    );

    typedef struct {
        string      name;
        logic       rst;
        logic       fs;
        logic       ba;
        logic [5:0] cnt;
        logic       done;
        logic       pulse;
        logic [3:0] off;
    } vec_t;

    vec_t vecs[$];
    int   total = 0;
    int   bad   = 0;

    function automatic void add(string name, logic r, logic fs, logic ba,
                                int cnt, logic done, logic pulse, int off);
        vec_t v;
        v.name = name; v.rst = r; v.fs = fs; v.ba = ba;
        v.cnt = 6'(cnt); v.done = done; v.pulse = pulse; v.off = 4'(off);
        vecs.push_back(v);
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, let the edge sample them, settle before checking.
    task automatic step(logic r, logic fs, logic ba);
        rst = r; frame_start = fs; beat_accept = ba;
        @(posedge clk);
        #1;
        rst = 1'b0; frame_start = 1'b0; beat_accept = 1'b0;
    endtask

    initial begin
        //   name           rst fs ba  cnt done pulse off
        add("reset",        1, 0, 0,  0,  0,   0,   0);
        add("fs",           0, 1, 0,  0,  0,   0,   0);
        add("beat1",        0, 0, 1,  8,  0,   0,   0);
        add("beat2",        0, 0, 1, 16,  0,   0,   0);
        add("beat3_cross",  0, 0, 1, 24,  1,   1,   2);
        add("idle_after",   0, 0, 0, 24,  1,   0,   2);
        add("extra1",       0, 0, 1, 24,  1,   0,   2);
        add("extra2",       0, 0, 1, 24,  1,   0,   2);
        add("fs_clear",     0, 1, 0,  0,  0,   0,   0);
        add("f2_beat1",     0, 0, 1,  8,  0,   0,   0);
        add("f2_beat2",     0, 0, 1, 16,  0,   0,   0);
        add("f2_beat3",     0, 0, 1, 24,  1,   1,   2);
        add("fs_ba",        0, 1, 1,  8,  0,   0,   0);
        add("fsba_beat2",   0, 0, 1, 16,  0,   0,   0);
        add("fsba_gap",     0, 0, 0, 16,  0,   0,   0);
        add("fsba_beat3",   0, 0, 1, 24,  1,   1,   2);
        add("f4_fs",        0, 1, 0,  0,  0,   0,   0);
        add("f4_beat1",     0, 0, 1,  8,  0,   0,   0);
        add("f4_beat2",     0, 0, 1, 16,  0,   0,   0);
        add("mid_rst",      1, 0, 0,  0,  0,   0,   0);
        add("nofs_beat1",   0, 0, 1,  8,  0,   0,   0);
        add("nofs_beat2",   0, 0, 1, 16,  0,   0,   0);
        add("nofs_beat3",   0, 0, 1, 24,  1,   1,   2);
        add("rst_done",     1, 0, 0,  0,  0,   0,   0);
        add("fsba_again",   0, 1, 1,  8,  0,   0,   0);
        add("rst_prio",     1, 1, 1,  0,  0,   0,   0);
        add("r_beat1",      0, 0, 1,  8,  0,   0,   0);
        add("r_beat2",      0, 0, 1, 16,  0,   0,   0);
        add("restart_mid",  0, 1, 1,  8,  0,   0,   0);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].fs, vecs[i].ba);
            chk({vecs[i].name, ".cnt"},   32'(d64_cnt),   32'(vecs[i].cnt));
            chk({vecs[i].name, ".done"},  32'(d64_done),  32'(vecs[i].done));
            chk({vecs[i].name, ".pulse"}, 32'(d64_pulse), 32'(vecs[i].pulse));
            chk({vecs[i].name, ".off"},   32'(d64_off),   32'(vecs[i].off));
        end

        // One byte per beat: the 18th beat crosses with offset 18-17 = 1.
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        chk("d8.fs_cnt", 32'(d8_cnt), 32'd0);
        for (int b = 1; b <= 17; b++) begin
            step(1'b0, 1'b0, 1'b1);
            chk($sformatf("d8.beat%0d_cnt", b), 32'(d8_cnt), 32'(b));
            chk($sformatf("d8.beat%0d_done", b), 32'(d8_done), 32'd0);
            chk($sformatf("d8.beat%0d_pulse", b), 32'(d8_pulse), 32'd0);
        end
        step(1'b0, 1'b0, 1'b1);
        chk("d8.beat18_cnt",   32'(d8_cnt),   32'd18);
        chk("d8.beat18_done",  32'(d8_done),  32'd1);
        chk("d8.beat18_pulse", 32'(d8_pulse), 32'd1);
        chk("d8.beat18_off",   32'(d8_off),   32'd1);
        step(1'b0, 1'b0, 1'b1);
        chk("d8.beat19_cnt",   32'(d8_cnt),   32'd18);
        chk("d8.beat19_pulse", 32'(d8_pulse), 32'd0);
        chk("d8.beat19_off",   32'(d8_off),   32'd1);

        // 32 bytes per beat: the first beat already covers the 18-byte header.
        step(1'b1, 1'b0, 1'b0);
        chk("d256.rst_done", 32'(d256_done), 32'd0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        chk("d256.b1_cnt",   32'(d256_cnt),   32'd32);
        chk("d256.b1_done",  32'(d256_done),  32'd1);
        chk("d256.b1_pulse", 32'(d256_pulse), 32'd1);
        chk("d256.b1_off",   32'(d256_off),   32'd18);
        step(1'b0, 1'b0, 1'b1);
        chk("d256.b2_cnt",   32'(d256_cnt),   32'd32);
        chk("d256.b2_pulse", 32'(d256_pulse), 32'd0);
        step(1'b0, 1'b1, 1'b0);
        chk("d256.fs_off",   32'(d256_off),   32'd0);
        chk("d256.fs_done",  32'(d256_done),  32'd0);
        step(1'b0, 1'b1, 1'b1);
        chk("d256.fsba_cnt",   32'(d256_cnt),   32'd32);
        chk("d256.fsba_pulse", 32'(d256_pulse), 32'd1);
        chk("d256.fsba_off",   32'(d256_off),   32'd18);
        step(1'b0, 1'b1, 1'b1);
        chk("d256.fsba2_pulse", 32'(d256_pulse), 32'd1);
        step(1'b0, 1'b0, 1'b0);
        chk("d256.idle_pulse", 32'(d256_pulse), 32'd0);
        chk("d256.idle_off",   32'(d256_off),   32'd18);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
